// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and the default operand width.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Restoring unsigned divider core: one shift-subtract step per clock on
// operand magnitudes; sign handling is done by the parent.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
    // A negative trial difference means the divisor did not fit: restore.
    if (diff[XLEN]) begin
      rem_d = shifted[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider on magnitudes, with sign fix-up and RISC-V corner cases.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] C
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [2:0]       op_q;
  logic             neg_q, a_neg_q, divz_q, ovf_q;
  logic [XLEN-1:0]  a_raw_q, mcand_q, hi_q, lo_q, c_q;

  logic             accept, a_signed, b_signed, a_neg, b_neg, divz_in, ovf_in;
  logic [XLEN-1:0]  a_mag, b_mag, quo, rem, quo_s, rem_s, result;
  logic [XLEN:0]    mul_sum;
  logic [2*XLEN-1:0] prod_s;

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      MDU_MULH, MDU_DIV, MDU_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MDU_MULHSU:                          a_signed = 1'b1;
      MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU: a_signed = 1'b0;
      default:                             a_signed = 1'b0;
    endcase
    a_neg   = a_signed & A[XLEN-1];
    b_neg   = b_signed & B[XLEN-1];
    a_mag   = a_neg ? -A : A;
    b_mag   = b_neg ? -B : B;
    divz_in = funct3[2] && (B == '0);
    ovf_in  = (funct3 == MDU_DIV || funct3 == MDU_REM) && (A == MIN_NEG) && (&B);
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      // Corner cases need no iteration; their result is fixed by the ISA.
      state_d = (divz_in || ovf_in) ? ST_FIX : ST_CALC;
    end else begin
      case (state_q)
        ST_CALC: if (count_q == LAST) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Shift-add step: add multiplicand into the upper half, shift the pair right.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_raw_q <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      c_q     <= '0;
    end else begin
      if (accept) begin
        count_q <= '0;
        op_q    <= funct3;
        neg_q   <= a_neg ^ b_neg;
        a_neg_q <= a_neg;
        divz_q  <= divz_in;
        ovf_q   <= ovf_in;
        a_raw_q <= A;
        mcand_q <= a_mag;
        hi_q    <= '0;
        lo_q    <= b_mag;
      end else if (state_q == ST_CALC) begin
        count_q <= count_q + 1'b1;
        hi_q    <= mul_sum[XLEN:1];
        lo_q    <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
      if (state_q == ST_FIX) c_q <= result;
    end
  end

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .step_i     (state_q == ST_CALC),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quotient_o (quo),
    .remainder_o(rem)
  );

  always_comb begin
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = neg_q ? -quo : quo;
    rem_s  = a_neg_q ? -rem : rem;
    result = '0;
    if (op_q[2]) begin
      // op_q[1] selects the remainder flavours (REM/REMU).
      if (divz_q)      result = op_q[1] ? a_raw_q : '1;
      else if (ovf_q)  result = op_q[1] ? '0 : MIN_NEG;
      else             result = op_q[1] ? rem_s : quo_s;
    end else begin
      result = (op_q == MDU_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);
  assign C    = c_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed ISA cases plus randomized operations
// compared against a plain-arithmetic RV32M reference model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] A, B, C;
  logic        busy, done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_c;

  mdu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .funct3(funct3),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .C     (C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      MDU_MUL, MDU_MULHU: p = ua * ub;
      MDU_MULH:           p = sa * sb;
      MDU_MULHSU:         p = sa * ub;
      MDU_DIV:  p = (b == 0) ? -64'sd1 : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb);
      MDU_DIVU: p = (b == 0) ? -64'sd1 : ua / ub;
      MDU_REM:  p = (b == 0) ? sa : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 64'sd0 : sa % sb);
      default:  p = (b == 0) ? ua : ua % ub;
    endcase
    pb = p;
    return (f == MDU_MULH || f == MDU_MULHSU || f == MDU_MULHU) ? pb[63:32] : pb[31:0];
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 2;
    if ((f == MDU_DIV || f == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return XLEN + 2;
  endfunction

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called in cycle 1 after the accepting edge; follows the op to its done pulse.
  task automatic wait_result(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input bit chain, input logic [2:0] nf,
                             input logic [31:0] na, input logic [31:0] nb, input bit poke);
    int          cyc;
    int          lat;
    logic [31:0] exp;
    cyc = 1;
    exp = model(f, a, b);
    lat = latency(f, a, b);
    while (done !== 1'b1 && cyc < 60) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_c_hold"}, C, last_c);
      if (poke && cyc == 5) begin
        funct3 = MDU_MUL; A = 32'd9; B = 32'd9; start = 1'b1;
      end else begin
        funct3 = 3'($urandom); A = $urandom; B = $urandom; start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(cyc), 32'(lat));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check(tag, C, exp);
    last_c = exp;
    if (chain) begin
      funct3 = nf; A = na; B = nb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_c_after"}, C, last_c);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    launch(f, a, b);
    wait_result(tag, f, a, b, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; funct3 = '0; A = '0; B = '0;
    last_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_c", C, 32'd0);
    rst = 1'b0;

    run("mul_7x6",        MDU_MUL,    32'd7,          32'd6);
    run("mulh_min_min",   MDU_MULH,   32'h8000_0000,  32'h8000_0000);
    run("mulhu_ones",     MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run("mulhsu_m1x2",    MDU_MULHSU, 32'hFFFF_FFFF,  32'd2);
    run("div_m7_2",       MDU_DIV,    -32'sd7,        32'd2);
    run("rem_m7_2",       MDU_REM,    -32'sd7,        32'd2);
    run("divu_100_7",     MDU_DIVU,   32'd100,        32'd7);
    run("remu_100_7",     MDU_REMU,   32'd100,        32'd7);
    run("div_by_zero",    MDU_DIV,    32'd5,          32'd0);
    run("rem_by_zero",    MDU_REM,    32'd5,          32'd0);
    run("div_overflow",   MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    run("rem_overflow",   MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF);

    launch(MDU_MUL, 32'd3, 32'd4);
    wait_result("mul_ignore_start", MDU_MUL, 32'd3, 32'd4, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    launch(MDU_DIV, -32'sd100, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_done", 32'(done), 32'd0);
    check("midop_rst_c", C, 32'd0);
    last_c = '0;
    run("divu_after_rst", MDU_DIVU, 32'd9, 32'd3);

    launch(MDU_DIVU, 32'd100, 32'd7);
    wait_result("b2b_first", MDU_DIVU, 32'd100, 32'd7, 1'b1, MDU_MUL, 32'd2, 32'd3, 1'b0);
    wait_result("b2b_mul", MDU_MUL, 32'd2, 32'd3, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      run("random", rf, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
